// File: rtl/wire_arith_array.sv
// Multi-channel add/subtract/accumulate/clear engine between FrontPanel wire-ins
// and wire-outs; one channel is processed per clock after a start pulse.
module wire_arith_array #(
  parameter int WIDTH    = 32,
  parameter int CHANNELS = 2,
  parameter int SAT      = 0
) (
  input  logic                      ti_clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [1:0]                mode,
  input  logic [CHANNELS*WIDTH-1:0] opa,
  input  logic [CHANNELS*WIDTH-1:0] opb,
  output logic [CHANNELS*WIDTH-1:0] result,
  output logic [CHANNELS-1:0]       ovf,
  output logic                      busy,
  output logic                      done
);

  localparam int IW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                    state_q;
  logic [IW-1:0]             idx_q;
  logic [1:0]                mode_q;
  logic [CHANNELS*WIDTH-1:0] a_q, b_q, result_q;
  logic [CHANNELS-1:0]       ovf_q;
  logic                      busy_q, done_q;

  logic [WIDTH-1:0] a_k, b_k, r_k, res_d;
  logic [WIDTH:0]   sum_w, diff_w;
  logic [WIDTH+1:0] acc_w;
  logic             acc_ov, ovf_d;

  always_comb begin
    a_k    = a_q[int'(idx_q)*WIDTH +: WIDTH];
    b_k    = b_q[int'(idx_q)*WIDTH +: WIDTH];
    r_k    = result_q[int'(idx_q)*WIDTH +: WIDTH];
    sum_w  = {1'b0, a_k} + {1'b0, b_k};
    diff_w = {1'b0, a_k} - {1'b0, b_k};
    acc_w  = {2'b00, r_k} + {2'b00, a_k} + {2'b00, b_k};
    acc_ov = |acc_w[WIDTH+1:WIDTH];
    res_d  = '0;
    ovf_d  = 1'b0;
    case (mode_q)
      2'b00: begin
        ovf_d = sum_w[WIDTH];
        res_d = ((SAT != 0) && sum_w[WIDTH]) ? '1 : sum_w[WIDTH-1:0];
      end
      2'b01: begin
        // The extra MSB of the difference is the borrow (a < b).
        ovf_d = diff_w[WIDTH];
        res_d = ((SAT != 0) && diff_w[WIDTH]) ? '0 : diff_w[WIDTH-1:0];
      end
      2'b10: begin
        ovf_d = ovf_q[idx_q] | acc_ov;
        res_d = ((SAT != 0) && acc_ov) ? '1 : acc_w[WIDTH-1:0];
      end
      default: begin
        ovf_d = 1'b0;
        res_d = '0;
      end
    endcase
  end

  always_ff @(posedge ti_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      mode_q   <= '0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      ovf_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            a_q     <= opa;
            b_q     <= opb;
            mode_q  <= mode;
            idx_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          result_q[int'(idx_q)*WIDTH +: WIDTH] <= res_d;
          ovf_q[idx_q] <= ovf_d;
          if (int'(idx_q) == CHANNELS - 1) begin
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign result = result_q;
  assign ovf    = ovf_q;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule

// File: tb/tb_wire_arith_array.sv
// Checks wrap, saturating and 4-channel instances against a whole-operation
// reference model, with directed cases followed by random operations.
module tb_wire_arith_array;

  logic         ti_clk = 1'b0;
  logic         rst_n  = 1'b0;
  logic         start  = 1'b0;
  logic [1:0]   mode   = 2'b00;
  logic [31:0]  a_in [4];
  logic [31:0]  b_in [4];
  logic [63:0]  opa2, opb2, res_w, res_s;
  logic [127:0] opa4, opb4, res_f;
  logic [1:0]   ovf_w, ovf_s;
  logic [3:0]   ovf_f;
  logic         busy_w, busy_s, busy_f, done_w, done_s, done_f;

  int compared   = 0;
  int mismatched = 0;

  localparam longint unsigned LIM = 64'h1_0000_0000;
  longint unsigned res_m [3][4];
  bit              ovf_m [3][4];

  assign opa2 = {a_in[1], a_in[0]};
  assign opb2 = {b_in[1], b_in[0]};
  assign opa4 = {a_in[3], a_in[2], a_in[1], a_in[0]};
  assign opb4 = {b_in[3], b_in[2], b_in[1], b_in[0]};

  always #5 ti_clk = ~ti_clk;

  wire_arith_array #(.WIDTH(32), .CHANNELS(2), .SAT(0)) u_wrap (
    .ti_clk(ti_clk), .rst_n(rst_n), .start(start), .mode(mode),
    .opa(opa2), .opb(opb2), .result(res_w), .ovf(ovf_w), .busy(busy_w), .done(done_w));

  wire_arith_array #(.WIDTH(32), .CHANNELS(2), .SAT(1)) u_sat (
    .ti_clk(ti_clk), .rst_n(rst_n), .start(start), .mode(mode),
    .opa(opa2), .opb(opb2), .result(res_s), .ovf(ovf_s), .busy(busy_s), .done(done_s));

  wire_arith_array #(.WIDTH(32), .CHANNELS(4), .SAT(0)) u_four (
    .ti_clk(ti_clk), .rst_n(rst_n), .start(start), .mode(mode),
    .opa(opa4), .opb(opb4), .result(res_f), .ovf(ovf_f), .busy(busy_f), .done(done_f));

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++)
      for (int k = 0; k < 4; k++) begin
        res_m[i][k] = 0;
        ovf_m[i][k] = 1'b0;
      end
  endtask

  // Applies one whole operation to every channel of every instance.
  task automatic model_op(input logic [1:0] m);
    for (int i = 0; i < 3; i++) begin
      int n   = (i == 2) ? 4 : 2;
      bit sat = (i == 1);
      for (int k = 0; k < n; k++) begin
        longint unsigned a = a_in[k];
        longint unsigned b = b_in[k];
        longint unsigned s;
        case (m)
          2'b00: begin
            s = a + b;
            ovf_m[i][k] = (s >= LIM);
            res_m[i][k] = (sat && s >= LIM) ? LIM - 1 : s % LIM;
          end
          2'b01: begin
            ovf_m[i][k] = (a < b);
            res_m[i][k] = (sat && a < b) ? 0 : (a + LIM - b) % LIM;
          end
          2'b10: begin
            s = res_m[i][k] + a + b;
            ovf_m[i][k] = ovf_m[i][k] || (s >= LIM);
            res_m[i][k] = (sat && s >= LIM) ? LIM - 1 : s % LIM;
          end
          default: begin
            res_m[i][k] = 0;
            ovf_m[i][k] = 1'b0;
          end
        endcase
      end
    end
  endtask

  function automatic logic [127:0] exp_res(input int i, input int n);
    logic [127:0] v = '0;
    for (int k = 0; k < n; k++) v[k*32 +: 32] = res_m[i][k][31:0];
    return v;
  endfunction

  function automatic logic [127:0] exp_ovf(input int i, input int n);
    logic [127:0] v = '0;
    for (int k = 0; k < n; k++) v[k] = ovf_m[i][k];
    return v;
  endfunction

  task automatic chk_results();
    chk("res_wrap", {64'h0, res_w}, exp_res(0, 2));
    chk("ovf_wrap", {126'h0, ovf_w}, exp_ovf(0, 2));
    chk("res_sat",  {64'h0, res_s}, exp_res(1, 2));
    chk("ovf_sat",  {126'h0, ovf_s}, exp_ovf(1, 2));
    chk("res_four", res_f, exp_res(2, 4));
    chk("ovf_four", {124'h0, ovf_f}, exp_ovf(2, 4));
  endtask

  task automatic chk_idle_zero(input string tag);
    chk({tag, "_res_w"}, {64'h0, res_w}, '0);
    chk({tag, "_res_f"}, res_f, '0);
    chk({tag, "_ovf_f"}, {124'h0, ovf_f}, '0);
    chk({tag, "_ctl"}, {122'h0, busy_w, busy_s, busy_f, done_w, done_s, done_f}, '0);
  endtask

  // variant 0: plain op; 1: second start plus operand change at E1; 2: reset after E1.
  task automatic run_op(input logic [1:0] m, input int variant);
    @(negedge ti_clk);
    mode  = m;
    start = 1'b1;
    @(posedge ti_clk);
    model_op(m);
    #1;
    chk("busy_after_e0", {125'h0, busy_w, busy_s, busy_f}, 128'b111);
    if (variant == 1) begin
      a_in = '{default: 32'h0};
      mode = ~m;
    end else begin
      start = 1'b0;
    end
    for (int cyc = 1; cyc <= 6; cyc++) begin
      @(posedge ti_clk);
      #1;
      if (cyc == 1) start = 1'b0;
      if (variant == 2 && cyc == 1) begin
        rst_n = 1'b0;
        #1;
        model_reset();
        chk_idle_zero("midrun_reset");
        @(negedge ti_clk);
        rst_n = 1'b1;
        return;
      end
      @(negedge ti_clk);
      chk("busy2", {127'h0, busy_w}, {127'h0, cyc <= 2});
      chk("done2", {126'h0, done_w, done_s}, {126'h0, cyc == 2, cyc == 2});
      chk("busy4", {127'h0, busy_f}, {127'h0, cyc <= 4});
      chk("done4", {127'h0, done_f}, {127'h0, cyc == 4});
    end
    chk_results();
  endtask

  task automatic set_ops(input logic [31:0] a0, b0, a1, b1);
    a_in = '{a0, a1, 32'h0, 32'h0};
    b_in = '{b0, b1, 32'h0, 32'h0};
  endtask

  initial begin
    a_in = '{default: 32'h0};
    b_in = '{default: 32'h0};
    model_reset();
    #12;
    chk_idle_zero("reset");
    @(negedge ti_clk);
    rst_n = 1'b1;

    set_ops(32'd5, 32'd7, 32'hFFFF_FFFF, 32'd1);
    run_op(2'b00, 0);
    chk("tp_add_wrap", {64'h0, res_w, ovf_w}, {64'h0, 32'h0, 32'd12, 2'b10});
    chk("tp_add_sat",  {64'h0, res_s, ovf_s}, {64'h0, 32'hFFFF_FFFF, 32'd12, 2'b10});

    set_ops(32'd3, 32'd5, 32'd9, 32'd4);
    run_op(2'b01, 0);
    chk("tp_sub_wrap", {64'h0, res_w, ovf_w}, {64'h0, 32'd5, 32'hFFFF_FFFE, 2'b01});
    chk("tp_sub_sat",  {64'h0, res_s, ovf_s}, {64'h0, 32'd5, 32'h0, 2'b01});

    set_ops(32'd10, 32'd20, 32'd0, 32'd0);
    run_op(2'b11, 0);
    for (int i = 0; i < 3; i++) run_op(2'b10, 0);
    chk("tp_acc90", {94'h0, res_w[31:0], ovf_w[0]}, {94'h0, 32'd90, 1'b0});
    set_ops(32'hFFFF_FFFF, 32'd0, 32'd0, 32'd0);
    run_op(2'b10, 0);
    chk("tp_acc_wrap", {94'h0, res_w[31:0], ovf_w[0]}, {94'h0, 32'd89, 1'b1});
    set_ops(32'd1, 32'd0, 32'd0, 32'd0);
    run_op(2'b10, 0);
    chk("tp_acc_sticky", {127'h0, ovf_w[0]}, 128'h1);
    run_op(2'b11, 0);
    chk("tp_clear", {62'h0, res_w, ovf_w}, '0);

    set_ops(32'd100, 32'd23, 32'hFFFF_FFF0, 32'h20);
    run_op(2'b00, 1);
    chk("tp_busy_protect", {64'h0, res_w}, {64'h0, 32'h10, 32'd123});

    a_in = '{32'd1, 32'd2, 32'd3, 32'd4};
    b_in = '{32'd1, 32'd2, 32'd3, 32'd4};
    run_op(2'b00, 2);
    set_ops(32'd1, 32'd1, 32'd0, 32'd0);
    run_op(2'b00, 0);
    chk("tp_after_reset", {96'h0, res_f[31:0]}, 128'd2);

    for (int t = 0; t < 24; t++) begin
      for (int k = 0; k < 4; k++) begin
        case ($urandom_range(3))
          0: a_in[k] = 32'hFFFF_FFFF - $urandom_range(3);
          1: a_in[k] = $urandom_range(3);
          default: a_in[k] = $urandom;
        endcase
        b_in[k] = ($urandom_range(1) == 1) ? $urandom : $urandom_range(7);
      end
      run_op(2'($urandom_range(3)), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
